mdr_load_fetch: RTL and testbench

- Upstream neighbour of the load-size unit in the multicycle datapath.
- Accepts a load request (address plus size code) from the control unit and issues a word-aligned memory read with a ready/ack handshake.
- Right-aligns the addressed byte or halfword and latches the result into the memory data register (RegMDROut), which drives the load-size unit directly.
- Flags misaligned accesses and memory timeouts.

---
 rtl/mdr_load_fetch.sv | 167 ++++++++++++++++
 tb/tb_mdr_load_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_load_fetch.sv
// rtl/mdr_load_fetch.sv - load fetch front end feeding the memory data register
//
// Takes a load request (byte address plus size code) and issues one
// word-aligned memory read with a ready/ack handshake. It then right-aligns
// the addressed byte or halfword into RegMDROut for the load-size unit.
// Misaligned requests and memory timeouts complete with err set.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        load request, sampled only when idle
//   addr         byte address of the load
//   LSControl    size code: 00 byte, 01 halfword, 10 word, 11 reserved
//   mem_rd       memory read strobe
//   mem_addr     word-aligned memory address
//   mem_data_in  memory read data, valid with mem_ack
//   mem_ack      memory completion, honoured only while requesting
//   RegMDROut    memory data register, right-aligned load data
//   busy         high while a load is in flight or completing
//   done         one-cycle completion pulse
//   err          error flag for the most recently completed load

module mdr_load_fetch #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  LSControl,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ack,
    output logic [31:0] RegMDROut,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mdr_q, mdr_d;
    logic        err_q, err_d;
    logic        misaligned;
    logic [31:0] aligned_data;

    // The reserved size code is treated as misaligned so it never reaches memory.
    always_comb begin
        misaligned = 1'b0;
        case (LSControl)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Right-align the addressed lane; upper bits are left as the shift leaves
    // them because the load-size unit masks or extends them afterwards.
    always_comb begin
        aligned_data = mem_data_in;
        case (size_q)
            SZ_HALF: aligned_data = mem_data_in >> {off_q[1], 4'b0000};
            SZ_BYTE: aligned_data = mem_data_in >> {off_q, 3'b000};
            default: aligned_data = mem_data_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        maddr_d = maddr_q;
        mdr_d   = mdr_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    off_d  = addr[1:0];
                    size_d = LSControl;
                    err_d  = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        maddr_d = {addr[31:2], 2'b00};
                        rd_d    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    mdr_d   = aligned_data;
                    rd_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    rd_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                rd_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            cnt_q   <= 8'd0;
            rd_q    <= 1'b0;
            maddr_q <= 32'd0;
            mdr_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            maddr_q <= maddr_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd    = rd_q;
    assign mem_addr  = maddr_q;
    assign RegMDROut = mdr_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mdr_load_fetch.sv
// tb/tb_mdr_load_fetch.sv - scoreboard bench for mdr_load_fetch

module tb_mdr_load_fetch;

    localparam int TO = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] addr;
    logic [1:0]  LSControl;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_ack;
    logic [31:0] RegMDROut;
    logic        busy;
    logic        done;
    logic        err;

    mdr_load_fetch #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .addr        (addr),
        .LSControl   (LSControl),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_ack     (mem_ack),
        .RegMDROut   (RegMDROut),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mdr;
        logic        err;
        int          rd_cycles;
        logic [31:0] maddr;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_mdr = 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one load. ack_delay is the index of the mem_rd cycle carrying the
    // ack (0 = same cycle mem_rd first appears); negative means never ack.
    task automatic do_load(input logic [31:0] a, input logic [1:0] ls,
                           input logic [31:0] data, input int ack_delay,
                           input bit poke);
        exp_t e, got;
        bit   bad;
        bit   acked;
        int   rd_cycles;
        bit   seen_done;

        bad   = (ls == 2'b11) || (ls == 2'b01 && a[0]) || (ls == 2'b10 && a[1:0] != 2'b00);
        acked = !bad && ack_delay >= 0 && ack_delay < TO;
        e.maddr = {a[31:2], 2'b00};
        if (bad) begin
            e.err = 1'b1; e.mdr = exp_mdr; e.rd_cycles = 0;
        end else if (!acked) begin
            e.err = 1'b1; e.mdr = exp_mdr; e.rd_cycles = TO;
        end else begin
            e.err = 1'b0; e.rd_cycles = ack_delay + 1;
            case (ls)
                2'b00:   e.mdr = data >> (8 * a[1:0]);
                2'b01:   e.mdr = data >> (16 * a[1]);
                default: e.mdr = data;
            endcase
        end
        sb.push_back(e);

        start = 1'b1; addr = a; LSControl = ls; mem_data_in = data;
        tick();
        start = 1'b0;
        rd_cycles = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen_done = 1'b1;
                if (poke) begin
                    start = 1'b1; addr = 32'h0000_0100; LSControl = 2'b10;
                end
                break;
            end
            if (mem_rd) begin
                if (rd_cycles == 0) begin
                    vectors++;
                    if (mem_addr !== e.maddr) begin
                        miscompares++;
                        $display("FAIL mem_addr: got %h expected %h", mem_addr, e.maddr);
                    end
                end
                mem_ack = (rd_cycles == ack_delay);
                start   = poke && (rd_cycles == 1);
                addr    = 32'h0000_0200;
                rd_cycles++;
            end else begin
                mem_ack = 1'b0;
            end
            tick();
        end
        mem_ack = 1'b0;

        vectors++;
        if (!seen_done) begin
            miscompares++;
            $display("FAIL done_timeout: got no done within budget expected done pulse");
        end
        got = sb.pop_front();
        vectors++;
        if (RegMDROut !== got.mdr) begin
            miscompares++;
            $display("FAIL mdr: got %h expected %h", RegMDROut, got.mdr);
        end
        vectors++;
        if (err !== got.err) begin
            miscompares++;
            $display("FAIL err: got %b expected %b", err, got.err);
        end
        vectors++;
        if (rd_cycles !== got.rd_cycles) begin
            miscompares++;
            $display("FAIL mem_rd_width: got %0d expected %0d", rd_cycles, got.rd_cycles);
        end
        exp_mdr = got.mdr;

        tick();
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0 || err !== got.err) begin
            miscompares++;
            $display("FAIL after_done: got done=%b busy=%b rd=%b err=%b expected 0 0 0 %b",
                     done, busy, mem_rd, err, got.err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; addr = '0; LSControl = '0;
        mem_ack = 1'b0; mem_data_in = '0;
        tick(); tick();
        vectors++;
        if ({mem_rd, busy, done, err} !== 4'b0 || mem_addr !== 32'd0 || RegMDROut !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rd=%b busy=%b done=%b err=%b addr=%h mdr=%h expected all zero",
                     mem_rd, busy, done, err, mem_addr, RegMDROut);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_word();
        do_load(32'h0000_0010, 2'b10, 32'hDEAD_BEEF, 1, 1'b0);
    endtask

    task automatic test_bytes();
        do_load(32'h0000_0013, 2'b00, 32'hAABB_CCDD, 0, 1'b0);
        vectors++;
        if (RegMDROut[7:0] !== 8'hAA) begin
            miscompares++;
            $display("FAIL byte3_lane: got %h expected aa", RegMDROut[7:0]);
        end
        for (int k = 0; k < 3; k++)
            do_load(32'h0000_0010 + k, 2'b00, 32'hAABB_CCDD, k, 1'b0);
        vectors++;
        if (RegMDROut[7:0] !== 8'hBB) begin
            miscompares++;
            $display("FAIL byte2_lane: got %h expected bb", RegMDROut[7:0]);
        end
    endtask

    task automatic test_halfword();
        do_load(32'h0000_0022, 2'b01, 32'h1234_5678, 1, 1'b0);
        vectors++;
        if (RegMDROut[15:0] !== 16'h1234) begin
            miscompares++;
            $display("FAIL half_hi: got %h expected 1234", RegMDROut[15:0]);
        end
        do_load(32'h0000_0020, 2'b01, 32'h1234_5678, 0, 1'b0);
        do_load(32'h0000_0021, 2'b01, 32'hFFFF_FFFF, 0, 1'b0);
        do_load(32'h0000_0032, 2'b10, 32'hFFFF_FFFF, 0, 1'b0);
        do_load(32'h0000_0030, 2'b11, 32'hFFFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_load(32'h0000_0040, 2'b10, 32'h5555_AAAA, -1, 1'b0);
        do_load(32'h0000_0044, 2'b10, 32'h0F0F_1234, TO - 1, 1'b0);
        do_load(32'h0000_0048, 2'b10, 32'h7777_7777, TO, 1'b0);
    endtask

    task automatic test_ignored();
        do_load(32'h0000_0050, 2'b10, 32'hCAFE_F00D, 2, 1'b1);
        mem_ack = 1'b1; mem_data_in = 32'h1111_2222;
        tick(); tick();
        vectors++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || RegMDROut !== exp_mdr) begin
            miscompares++;
            $display("FAIL stray_ack: got rd=%b busy=%b done=%b mdr=%h expected 0 0 0 %h",
                     mem_rd, busy, done, RegMDROut, exp_mdr);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_load(32'h0000_0060, 2'b10, 32'h0102_0304, 0, 1'b0);
        do_load(32'h0000_0066, 2'b01, 32'h0506_0708, 2, 1'b0);
        do_load(32'h0000_0061, 2'b00, 32'h090A_0B0C, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit any_done;
        start = 1'b1; addr = 32'h0000_0070; LSControl = 2'b10;
        tick();
        start = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (mem_rd !== 1'b0 || RegMDROut !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got rd=%b mdr=%h busy=%b done=%b expected 0 0 0 0",
                     mem_rd, RegMDROut, busy, done);
        end
        exp_mdr = 32'd0;
        tick();
        reset_n = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || mem_rd) any_done = 1'b1;
        end
        vectors++;
        if (any_done) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got done/mem_rd activity expected none");
        end
        do_load(32'h0000_0010, 2'b10, 32'hDEAD_BEEF, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_bytes();
        test_halfword();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
